// File: rtl/tt_extractor.sv
// tt_extractor: sweeps all 128 minterms of a 7-input function under test,
// assembles its 128-bit truth table and compares it against an expected ID.
// The result is handed out on a valid/ready interface.
// Optional build macro: TT_ONSET_EN adds onset_cnt, the number of ones in tt_out.
//
// state | meaning
// IDLE  | waiting for start; last result held on tt_out
// RUN   | driving idx on x_drv, sampling f_in after SETTLE idle cycles
// DONE  | tt_valid high, result held until tt_ready
module tt_extractor #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] exp_tt,
  output logic         busy,
  output logic [6:0]   x_drv,
  input  logic         f_in,
  output logic [127:0] tt_out,
  output logic         tt_match,
  output logic         tt_valid,
  input  logic         tt_ready
`ifdef TT_ONSET_EN
  ,
  output logic [7:0]   onset_cnt
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       tt_q, tt_d;
  logic [127:0]       exp_q, exp_d;
  logic               match_q, match_d;
  logic               valid_q, valid_d;
`ifdef TT_ONSET_EN
  logic [7:0]         onset_q, onset_d;
`endif

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      exp_q   <= '0;
      match_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef TT_ONSET_EN
      onset_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      valid_q <= valid_d;
`ifdef TT_ONSET_EN
      onset_q <= onset_d;
`endif
    end
  end

  // Next-state logic: accept, settle/sample sweep, and result handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    exp_d   = exp_q;
    match_d = match_q;
    valid_d = valid_q;
`ifdef TT_ONSET_EN
    onset_d = onset_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          exp_d   = exp_tt;
          tt_d    = '0;
          idx_d   = '0;
          cnt_d   = '0;
          match_d = 1'b0;
`ifdef TT_ONSET_EN
          onset_d = '0;
`endif
        end
      end
      S_RUN: begin
        if (cnt_q == SETTLE_C) begin
          cnt_d        = '0;
          tt_d[idx_q]  = f_in;
`ifdef TT_ONSET_EN
          onset_d      = onset_q + 8'(f_in);
`endif
          if (idx_q == 7'h7F) begin
            // Compare includes the bit written on this edge.
            state_d = S_DONE;
            valid_d = 1'b1;
            match_d = (tt_d == exp_q);
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (tt_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == S_RUN);
  assign x_drv    = idx_q;
  assign tt_out   = tt_q;
  assign tt_match = match_q;
  assign tt_valid = valid_q;
`ifdef TT_ONSET_EN
  assign onset_cnt = onset_q;
`endif

endmodule
